button_press_decoder: RTL
=========================

Name: button_press_decoder

Overview:
- Converts the raw, bouncy front-panel push-buttons of the range hood into clean one-cycle command pulses for the hood's mode state machine.
- Per button: 2-flop synchronizer, then debouncer.
- The power/menu button also gets a press-duration classifier, which emits either a short-press pulse or a long-press pulse.
- The level and self-clean buttons emit a single pulse on each debounced press.
- Sits between the board button pins and the mode FSM inputs; one instance per board.

Parameters:
- DEBOUNCE_CYCLES, 32'd2000000, consecutive stable cycles before a debounced level changes (20 ms at 100 MHz).
- LONG_PRESS_CYCLES, 32'd300000000, debounced hold cycles that classify a power press as long (3 s at 100 MHz); must be > 1.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous, active-high reset.
- power_menu_btn  input  1  raw power/menu button, active-high, asynchronous to clk.
- first_level_btn  input  1  raw button, active-high, async.
- second_level_btn  input  1  raw button, active-high, async.
- third_level_btn  input  1  raw button, active-high, async.
- self_clean_btn  input  1  raw button, active-high, async.
- power_menu_short_press  output  1  one-cycle pulse: power press released before the long threshold.
- power_menu_long_press  output  1  one-cycle pulse: power press held for LONG_PRESS_CYCLES.
- first_level_press  output  1  one-cycle pulse per debounced press.
- second_level_press  output  1  one-cycle pulse per debounced press.
- third_level_press  output  1  one-cycle pulse per debounced press.
- self_clean_press  output  1  one-cycle pulse per debounced press.
- power_menu_held  output  1  debounced level of the power button, for the display block.

Behaviour:
- **Reset** (rst high, async): all sync flops, debounced levels, counters and outputs go to 0; classifier FSM goes to P_IDLE. Takes effect immediately, even mid-press.
  - A button held through reset release is seen as a fresh press once debounced.
  - Such a press yields exactly one pulse (or a short/long classification for power).
- **Synchronizer:** two flops per button; the sync output lags the raw pin by 2 clocks.
- **Debouncer** (per button):
  - 32-bit stable counter increments while the sync value differs from the debounced level; it clears to 0 whenever they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level toggles and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is ignored entirely.
- **Level buttons** (first/second/third/self_clean):
  - Output pulse is registered and goes high for exactly one cycle, the cycle after the debounced rising edge.
  - Raw edge to pulse = DEBOUNCE_CYCLES+3 clocks.
  - No pulse on release. Holding produces no repeats.
- **Power classifier FSM:**
  - P_IDLE: on debounced rise -> P_HELD, hold_cnt cleared to 0.
  - P_HELD: hold_cnt increments every cycle.
    - Debounced fall with hold_cnt < LONG_PRESS_CYCLES-1 -> short pulse next cycle, go to P_IDLE.
    - hold_cnt == LONG_PRESS_CYCLES-1 while still held -> long pulse next cycle, go to P_LONG.
  - P_LONG: wait for debounced fall -> P_IDLE, no pulse on release.
  - Exactly one of short/long is emitted per power press, never both.
  - The long pulse fires during the hold and does not wait for release.
- **Timing:** hold_cnt is 32-bit and saturates (no wrap-around). Hold duration is measured in debounced time.
- **Independence:** all six pulse outputs are independent. Simultaneous presses of different buttons produce simultaneous pulses; priority resolution belongs to the consumer FSM.
- **power_menu_held:** equals the power button's debounced level, registered.
- **Pulse gap:** there are never two pulses on the same output in consecutive cycles. Minimum spacing is 2·DEBOUNCE_CYCLES.

Test Plan (bench uses DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20):
- first_level_btn raw 0->1 at cycle 10, held 30 cycles -> first_level_press high only at cycle 17 (=10+4+3); no pulse on release.
- power_menu_btn pressed clean for 10 cycles -> power_menu_short_press single pulse one cycle after the debounced fall; long pulse stays 0.
- power_menu_btn held 40 cycles -> power_menu_long_press single pulse 20 cycles after the debounced rise; release yields no short pulse; power_menu_held tracks the debounced level.
- third_level_btn bouncing 1,0,1,0 at 2-cycle intervals, then stable 1 -> exactly one third_level_press, counted from the last bounce; 3-cycle glitch alone -> no pulse.
- second_level_btn and self_clean_btn rise on the same cycle -> both pulses asserted on the same cycle.
- rst asserted mid power hold (cycle 12 of 20), button kept held, rst released -> outputs 0 immediately; after re-debounce, long pulse 20 cycles later; no short pulse.

Source files
------------

// File: rtl/button_press_decoder.sv
// Front-panel button conditioning for the range hood: synchronize and debounce each
// raw button, then emit one-cycle command pulses (short/long classified for power/menu).
module button_press_decoder #(
  parameter logic [31:0] DEBOUNCE_CYCLES   = 32'd2000000,
  parameter logic [31:0] LONG_PRESS_CYCLES = 32'd300000000
) (
  input  logic clk,
  input  logic rst,
  input  logic power_menu_btn,
  input  logic first_level_btn,
  input  logic second_level_btn,
  input  logic third_level_btn,
  input  logic self_clean_btn,
  output logic power_menu_short_press,
  output logic power_menu_long_press,
  output logic first_level_press,
  output logic second_level_press,
  output logic third_level_press,
  output logic self_clean_press,
  output logic power_menu_held
);

  typedef enum logic [1:0] {P_IDLE, P_HELD, P_LONG} power_state_t;

  logic [4:0]   btn_raw;
  logic [4:0]   sync_meta;
  logic [4:0]   sync_out;
  logic [4:0]   deb_level;
  logic [3:0]   deb_level_q;
  logic [31:0]  stable_cnt [5];
  logic [3:0]   level_pulse;
  power_state_t power_state;
  logic [31:0]  hold_cnt;
  logic         short_pulse;
  logic         long_pulse;

  // Bit 0 is power/menu; bits 4:1 are the plain press-only buttons.
  assign btn_raw = {self_clean_btn, third_level_btn, second_level_btn,
                    first_level_btn, power_menu_btn};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= '0;
      sync_out  <= '0;
    end else begin
      sync_meta <= btn_raw;
      sync_out  <= sync_meta;
    end
  end

  // The level only flips after the synced input has disagreed for a full window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_level <= '0;
      for (int i = 0; i < 5; i++) stable_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sync_out[i] == deb_level[i]) begin
          stable_cnt[i] <= '0;
        end else if (stable_cnt[i] == DEBOUNCE_CYCLES - 32'd1) begin
          deb_level[i]  <= ~deb_level[i];
          stable_cnt[i] <= '0;
        end else begin
          stable_cnt[i] <= stable_cnt[i] + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_level_q <= '0;
      level_pulse <= '0;
    end else begin
      deb_level_q <= deb_level[4:1];
      level_pulse <= deb_level[4:1] & ~deb_level_q;
    end
  end

  // A press held for the full long window is long even if it drops on that last cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      power_state <= P_IDLE;
      hold_cnt    <= '0;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
    end else begin
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
      case (power_state)
        P_IDLE: begin
          if (deb_level[0]) begin
            power_state <= P_HELD;
            hold_cnt    <= '0;
          end
        end
        P_HELD: begin
          if (hold_cnt != 32'hFFFF_FFFF) hold_cnt <= hold_cnt + 32'd1;
          if (hold_cnt == LONG_PRESS_CYCLES - 32'd1) begin
            long_pulse  <= 1'b1;
            power_state <= P_LONG;
          end else if (!deb_level[0]) begin
            short_pulse <= 1'b1;
            power_state <= P_IDLE;
          end
        end
        P_LONG: begin
          if (!deb_level[0]) power_state <= P_IDLE;
        end
        default: power_state <= P_IDLE;
      endcase
    end
  end

  assign power_menu_short_press = short_pulse;
  assign power_menu_long_press  = long_pulse;
  assign first_level_press      = level_pulse[0];
  assign second_level_press     = level_pulse[1];
  assign third_level_press      = level_pulse[2];
  assign self_clean_press       = level_pulse[3];
  assign power_menu_held        = deb_level[0];

endmodule
